// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode control store and its loader.
// Both the loader and the sequencer import this package.
package ucode_pkg;
  localparam int ADDR_W = 12;
  localparam int WORD_W = 35;
  localparam int BPW    = (WORD_W + 7) / 8;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [15:0] CNT_MAX = 16'(1 << ADDR_W);

  // Control-word bit positions, shared with the sequencer.
  localparam int SIG_END = 34;
  localparam int SIG_RET = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CSUM
  } state_t;
endpackage

// File: rtl/ucode_word_asm.sv
// Byte-to-word assembler: shifts BPW bytes MSB-first and emits a registered word
// one cycle after the last byte. It has no stall path and takes one byte per cycle.
module ucode_word_asm
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  output logic              word_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);
  logic [2:0]             idx_q;
  logic [(BPW-1)*8-1:0]   sh_q;
  logic [BPW*8-1:0]       full;

  assign full      = {sh_q, byte_dat};
  assign word_last = byte_vld && (idx_q == 3'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      sh_q       <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_last;
      if (clr) begin
        idx_q <= '0;
      end else if (byte_vld) begin
        sh_q <= full[(BPW-1)*8-1:0];
        if (word_last) begin
          idx_q <= '0;
          // The unused upper bits of the first byte drop off here.
          word  <= full[WORD_W-1:0];
        end else begin
          idx_q <= idx_q + 3'd1;
        end
      end
    end
  end
endmodule

// File: rtl/ucode_loader.sv
// Framed byte stream to control-store writer. A write strobe follows the last byte of each word by one cycle.
// It accepts one byte per cycle with no stall; in_ready drops only while in reset.
module ucode_loader
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t            state_q, state_d;
  logic              rdy_q;
  logic [7:0]        addr_h_q;
  logic [7:0]        cnt_h_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [12:0]       rem_q;
  logic [7:0]        csum_q;
  logic              done_q;
  logic              err_q;
  logic              acc;
  logic              sync_hit;
  logic              err_set;
  logic              done_set;
  logic              word_last;
  logic [15:0]       addr_full;
  logic [15:0]       cnt_full;

  assign acc       = in_valid && in_ready;
  assign sync_hit  = acc && (state_q == ST_IDLE) && (in_data == SYNC);
  assign addr_full = {addr_h_q, in_data};
  assign cnt_full  = {cnt_h_q, in_data};

  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    done_set = 1'b0;
    if (acc) begin
      case (state_q)
        ST_IDLE:   if (in_data == SYNC) state_d = ST_ADDR_H;
        ST_ADDR_H: state_d = ST_ADDR_L;
        ST_ADDR_L: begin
          if (addr_full[15:ADDR_W] != '0) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = ST_CNT_H;
          end
        end
        ST_CNT_H:  state_d = ST_CNT_L;
        ST_CNT_L: begin
          if (cnt_full == '0 || cnt_full > CNT_MAX) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA:   if (word_last && rem_q == 13'd1) state_d = ST_CSUM;
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (in_data == csum_q) done_set = 1'b1;
          else                   err_set  = 1'b1;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      addr_h_q  <= '0;
      cnt_h_q   <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      rem_q     <= '0;
      csum_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      done_q  <= done_set;
      if (err_set)       err_q <= 1'b1;
      else if (sync_hit) err_q <= 1'b0;

      if (sync_hit) begin
        csum_q <= '0;
      end else if (acc && state_q != ST_IDLE && state_q != ST_CSUM) begin
        csum_q <= csum_q ^ in_data;
      end

      if (acc) begin
        case (state_q)
          ST_ADDR_H: addr_h_q <= in_data;
          ST_ADDR_L: addr_q   <= addr_full[ADDR_W-1:0];
          ST_CNT_H:  cnt_h_q  <= in_data;
          ST_CNT_L:  rem_q    <= cnt_full[12:0];
          ST_DATA: begin
            if (word_last) begin
              // The address wraps naturally at the top of the store.
              wr_addr_q <= addr_q;
              addr_q    <= addr_q + ADDR_W'(1);
              rem_q     <= rem_q - 13'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ucode_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (sync_hit),
    .byte_vld   (acc && state_q == ST_DATA),
    .byte_dat   (in_data),
    .word_last  (word_last),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  assign in_ready = rdy_q;
  assign wr_addr  = wr_addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign error    = err_q;
  assign cpu_hold = busy | done_q | wr_en;
endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader with a write scoreboard.
module tb_ucode_loader;
  import ucode_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  ucode_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [34:0] d;
  } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  wr_t exp_q[$];
  wr_t got_q[$];
  int  got_t[$];
  logic [34:0] wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back(wr_t'{a: wr_addr, d: wr_data});
      got_t.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    chk("in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                            input logic [4:0] junk, input logic bad_cs);
    logic [7:0]  cs;
    logic [39:0] w40;
    send(SYNC);
    chk("err_clr_on_sync", {63'd0, error}, 64'd0);
    chk("hold_after_sync", {63'd0, cpu_hold}, 64'd1);
    cs = a[15:8] ^ a[7:0];
    send(a[15:8]);
    send(a[7:0]);
    if (a[15:12] != 4'd0) begin
      in_valid = 1'b0;
      return;
    end
    cs = cs ^ n[15:8] ^ n[7:0];
    send(n[15:8]);
    send(n[7:0]);
    if (n == 16'd0 || n > 16'd4096) begin
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(wr_t'{a: a[11:0] + 12'(i), d: wq[i]});
      w40 = {junk, wq[i]};
      for (int k = 4; k >= 0; k--) begin
        cs = cs ^ w40[k*8 +: 8];
        send(w40[k*8 +: 8]);
      end
    end
    send(bad_cs ? ~cs : cs);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    wr_t g, e;
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_addr"}, 64'(g.a), 64'(e.a));
      chk({tag, "_data"}, 64'(g.d), 64'(e.d));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_wr_en"},    {63'd0, wr_en},    64'd0);
    chk({tag, "_wr_addr"},  64'(wr_addr),      64'd0);
    chk({tag, "_wr_data"},  64'(wr_data),      64'd0);
    chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
    chk({tag, "_busy"},     {63'd0, busy},     64'd0);
    chk({tag, "_done"},     {63'd0, done},     64'd0);
    chk({tag, "_error"},    {63'd0, error},    64'd0);
  endtask

  initial begin
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
    chk("idle_after_reset", {63'd0, busy}, 64'd0);

    // Single all-ones word; first byte carries junk in its ignored upper bits.
    wq = '{35'h7_FFFF_FFFF};
    done_cnt = 0;
    send_frame(16'h0010, 16'd1, 5'h1F, 1'b0);
    chk("good_done", {63'd0, done}, 64'd1);
    chk("good_hold_at_done", {63'd0, cpu_hold}, 64'd1);
    @(posedge clk);
    #1;
    chk("good_hold_after_done", {63'd0, cpu_hold}, 64'd0);
    chk("good_done_one_cycle", {63'd0, done}, 64'd0);
    drain("good");
    chk("good_done_cnt", 64'(done_cnt), 64'd1);
    chk("good_error", {63'd0, error}, 64'd0);

    // Same frame, corrupted checksum: word still lands, no done.
    done_cnt = 0;
    send_frame(16'h0010, 16'd1, 5'h1F, 1'b1);
    chk("badcs_error", {63'd0, error}, 64'd1);
    chk("badcs_idle", {63'd0, busy}, 64'd0);
    drain("badcs");
    chk("badcs_no_done", 64'(done_cnt), 64'd0);
    chk("badcs_error_sticky", {63'd0, error}, 64'd1);

    // Address wrap with back-to-back bytes.
    wq = '{35'h1_0000_0001, 35'h2_5555_AAAA, 35'h4_DEAD_BEEF};
    done_cnt = 0;
    got_t.delete();
    send_frame(16'h0FFE, 16'd3, 5'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_nwr", 64'(got_t.size()), 64'd3);
    if (got_t.size() == 3) begin
      chk("wrap_gap0", 64'(got_t[1] - got_t[0]), 64'd5);
      chk("wrap_gap1", 64'(got_t[2] - got_t[1]), 64'd5);
    end
    drain("wrap");
    chk("wrap_done_cnt", 64'(done_cnt), 64'd1);
    chk("wrap_error", {63'd0, error}, 64'd0);

    // Illegal counts and an out-of-range address.
    wq.delete();
    send_frame(16'h0020, 16'h0000, 5'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("cnt0_error", {63'd0, error}, 64'd1);
    chk("cnt0_idle", {63'd0, busy}, 64'd0);
    drain("cnt0");
    send_frame(16'h0020, 16'h1001, 5'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("cnt4097_error", {63'd0, error}, 64'd1);
    chk("cnt4097_idle", {63'd0, busy}, 64'd0);
    drain("cnt4097");
    send_frame(16'h1000, 16'd1, 5'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("addr_error", {63'd0, error}, 64'd1);
    chk("addr_idle", {63'd0, busy}, 64'd0);
    drain("addr");

    // Garbage before SYNC, and SYNC bytes inside the payload.
    send(8'h00);
    send(8'h11);
    send(8'h22);
    chk("garbage_idle", {63'd0, busy}, 64'd0);
    wq = '{35'h5_A5A5_A5A5, 35'h0_12A5_3400};
    done_cnt = 0;
    send_frame(16'h0100, 16'd2, 5'h14, 1'b0);
    drain("embed");
    chk("embed_done_cnt", 64'(done_cnt), 64'd1);
    chk("embed_error", {63'd0, error}, 64'd0);

    // Reset in the middle of a word.
    done_cnt = 0;
    send(SYNC);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h01);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #10;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drain("midreset");
    chk("midreset_ready", {63'd0, in_ready}, 64'd1);

    wq = '{35'h1_2345_6789};
    send_frame(16'h0ABC, 16'd1, 5'h00, 1'b0);
    drain("reload");
    chk("reload_done_cnt", 64'(done_cnt), 64'd1);
    chk("reload_error", {63'd0, error}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
